// File: rtl/accelerator_pkg.sv
// Shared types for the PE result packer: FSM state encoding, EEW codes and
// the lane-geometry helpers derived from them.
package accelerator_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PACK,
    DRAIN,
    DONE
  } pe_packer_state_t;

  localparam logic [1:0] EEW_8  = 2'd0;
  localparam logic [1:0] EEW_16 = 2'd1;
  localparam logic [1:0] EEW_32 = 2'd2;

  // Effective element width saturates at 32 bits.
  function automatic logic [1:0] eew_code(input logic [1:0] vsew,
                                          input logic [1:0] widening);
    logic [2:0] sum;
    sum = {1'b0, vsew} + {1'b0, widening};
    return (sum >= 3'd2) ? EEW_32 : sum[1:0];
  endfunction

  function automatic logic [1:0] last_slot(input logic [1:0] eew);
    case (eew)
      EEW_8:   return 2'd3;
      EEW_16:  return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pack_lane_sel.sv
// Places a truncated element into its byte lanes of a 32-bit word and
// produces the matching byte-enable mask.
module pack_lane_sel
  import accelerator_pkg::*;
(
  input  logic [1:0]  eew,
  input  logic [1:0]  slot,
  input  logic [31:0] data,
  output logic [31:0] lane_data,
  output logic [3:0]  lane_be
);

  always_comb begin
    lane_data = '0;
    lane_be   = '0;
    case (eew)
      EEW_8: begin
        lane_data = {24'b0, data[7:0]} << {slot, 3'b000};
        lane_be   = 4'b0001 << slot;
      end
      EEW_16: begin
        lane_data = {16'b0, data[15:0]} << {slot[0], 4'b0000};
        lane_be   = 4'b0011 << {slot[0], 1'b0};
      end
      default: begin
        lane_data = data;
        lane_be   = 4'hF;
      end
    endcase
  end

endmodule

// File: rtl/pe_result_packer.sv
// Packs PE element results into byte-enabled 32-bit register-file writes.
// Optional PE_PACKER_ABORT_EN adds a synchronous abort input.
module pe_result_packer
  import accelerator_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int VL_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
`ifdef PE_PACKER_ABORT_EN
  input  logic              abort,
`endif
  input  logic              start,
  input  logic [1:0]        cfg_vsew,
  input  logic [1:0]        cfg_widening,
  input  logic [VL_W-1:0]   cfg_vl,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_be,
  output logic              busy,
  output logic              done
);

  pe_packer_state_t  state_q, state_d;
  logic [1:0]        eew_q;
  logic [VL_W-1:0]   vl_q;
  logic [VL_W-1:0]   elem_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        slot_q;
  logic [31:0]       buf_data_q;
  logic [3:0]        buf_be_q;

  logic [31:0]       lane_data;
  logic [3:0]        lane_be;
  logic              abort_hit;
  logic              accept;
  logic              wr_fire;
  logic              is_last;
  logic              word_done;

`ifdef PE_PACKER_ABORT_EN
  assign abort_hit = abort && (state_q != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign accept    = in_valid && in_ready && !abort_hit;
  assign wr_fire   = wr_en && wr_ready;
  assign is_last   = (elem_q == vl_q - VL_W'(1));
  assign word_done = (slot_q == last_slot(eew_q)) || is_last;

  pack_lane_sel u_lane_sel (
    .eew       (eew_q),
    .slot      (slot_q),
    .data      (in_data),
    .lane_data (lane_data),
    .lane_be   (lane_be)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (cfg_vl != '0) ? PACK : DONE;
      PACK:    if (accept && is_last) state_d = DRAIN;
      DRAIN:   if (wr_fire) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_hit) state_d = IDLE;
  end

  always_comb begin
    in_ready = (state_q == PACK) && !(wr_en && !wr_ready);
    busy     = (state_q == PACK) || (state_q == DRAIN);
    done     = (state_q == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eew_q      <= '0;
      vl_q       <= '0;
      elem_q     <= '0;
      addr_q     <= '0;
      slot_q     <= '0;
      buf_data_q <= '0;
      buf_be_q   <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_be      <= '0;
    end else if (abort_hit) begin
      elem_q     <= '0;
      slot_q     <= '0;
      buf_data_q <= '0;
      buf_be_q   <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_be      <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        eew_q      <= eew_code(cfg_vsew, cfg_widening);
        vl_q       <= cfg_vl;
        addr_q     <= cfg_addr;
        elem_q     <= '0;
        slot_q     <= '0;
        buf_data_q <= '0;
        buf_be_q   <= '0;
      end
      if (wr_fire) wr_en <= 1'b0;
      // A completing element may refill the write register in the same
      // cycle the previous word drains, so this overrides the clear above.
      if (accept) begin
        elem_q <= elem_q + VL_W'(1);
        if (word_done) begin
          wr_en      <= 1'b1;
          wr_addr    <= addr_q;
          wr_data    <= buf_data_q | lane_data;
          wr_be      <= buf_be_q | lane_be;
          addr_q     <= addr_q + ADDR_W'(1);
          slot_q     <= '0;
          buf_data_q <= '0;
          buf_be_q   <= '0;
        end else begin
          slot_q     <= slot_q + 2'd1;
          buf_data_q <= buf_data_q | lane_data;
          buf_be_q   <= buf_be_q | lane_be;
        end
      end
    end
  end

endmodule

// File: doc/pe_result_packer.md
# pe_result_packer

Downstream neighbour of the 32-bit processing element in the vector datapath. Consumes one element result per handshake from the PE output, truncates it to the effective destination element width (EEW = vsew + widening), packs consecutive elements into 32-bit words, and issues byte-enabled writes to the vector register file. It sequences one instruction's `vl` elements per `start` and pulses `done` when the final word has been written.

## Interface
Parameters:
- ADDR_W, 5: width of the register-file word address.
- VL_W, 8: width of the element count.

Ports:
- clk  in  1  clock. One clock domain; the block is synchronous to the rising edge.
- rst  in  1  reset. Asynchronous and active-high.
- start  in  1  starts an instruction. Sampled only in IDLE.
- cfg_vsew  in  2  element width code: 0 = 8b, 1 = 16b, 2 = 32b.
- cfg_widening  in  2  widening code: 1 = widening, 2 = quad widening, 0 = none.
- cfg_vl  in  VL_W  element count.
- cfg_addr  in  ADDR_W  first destination word address.
- in_valid  in  1  PE result valid.
- in_ready  out  1  the packer accepts the element this cycle.
- in_data  in  32  PE result. Bits above the EEW are ignored.
- wr_en  out  1  write request.
- wr_ready  in  1  register-file write accept.
- wr_addr  out  ADDR_W  write word address.
- wr_data  out  32  packed word.
- wr_be  out  4  byte enables.
- busy  out  1  an instruction is in progress.
- done  out  1  one-cycle completion pulse.

## Operation
- EEW code `e = min(cfg_vsew + cfg_widening, 2)`.
  - Element bytes: `1<<e`.
  - Slots per word: `4>>e`.
  - Slot `k` occupies bytes `[k<<e +: 1<<e]`.
- `start` in IDLE latches the configuration and clears the slot counter, element counter and assembly buffer.
  - `start` in any other state is ignored.
- State machine:
  - IDLE → PACK on `start` with `cfg_vl != 0`.
  - IDLE → DONE on `start` with `cfg_vl == 0`; no writes are issued.
  - PACK: each accepted element is ORed into its slot, and the slot's byte-enable bits are set.
    - Word completes when the slot reaches the last slot, or when the element is the last (`vl`-th) element.
    - On completion, the buffer moves to the write register: `wr_en = 1`, `wr_addr` = current address. The address then increments modulo 2^ADDR_W and the buffer clears.
  - PACK → DRAIN when the last element is accepted.
  - DRAIN → DONE on the `wr_en && wr_ready` handshake.
  - DONE → IDLE unconditionally after 1 cycle.
- In a partial final word, unwritten lanes have `wr_data` = 0 and `wr_be` = 0.
- `in_ready = (state == PACK) && !(wr_en && !wr_ready)`.
  - A word-completing element may therefore be accepted in the same cycle the pending write drains.
- `wr_en`, `wr_addr`, `wr_data` and `wr_be` hold stable while `wr_en && !wr_ready`.
- `busy = 1` in PACK and DRAIN.
- `done = 1` only in DONE.

## Timing
- Reset value of every output is 0. The FSM resets to IDLE, and all counters and buffers reset to 0.
- Reset asserted mid-instruction discards all state. No write or `done` follows.
- `start` at cycle 0: `busy = 1` and `in_ready` may be 1 from cycle 1.
- Element accepted at cycle t that completes a word: `wr_en = 1` at t+1.
- Final write handshake at cycle w: `done = 1` and `busy = 0` at w+1. IDLE at w+2, and a new `start` is accepted at w+2.
- With `wr_ready` held high, throughput is 1 element per cycle.

## Configuration
- `PE_PACKER_ABORT_EN`: defined:
  - Adds input port `abort` (1 bit), sampled synchronously.
  - `abort` in PACK, DRAIN or DONE moves the FSM to IDLE next cycle. It drops the assembly buffer and any pending write (`wr_en` → 0) and suppresses `done`.
  - `abort` in IDLE has no effect. `abort` has priority over `start` and over all handshakes.
- Undefined: the port is absent and behaviour is as above.

## Structure
- `accelerator_pkg` holds the `pe_packer_state_t` enum (IDLE, PACK, DRAIN, DONE) and the EEW code constants.
- Sub-module `pack_lane_sel` (combinational): maps slot index and EEW code to the shifted data and byte-enable mask.

## Test plan
- **8-bit packing:** `vsew=0`, `widening=0`, `vl=6`, `addr=3`, inputs 0x11..0x66.
  - Expect write addr 3 with 0x44332211, be 0xF.
  - Then addr 4 with 0x00006655, be 0x3.
  - `done` one cycle after the second handshake.
- **Widening to 16 bit:** `vsew=0`, `widening=1`, `vl=3`, inputs 0xFFFF1234, 0x0000ABCD, 0x12340F0F.
  - Expect addr 0 with 0xABCD1234, be 0xF.
  - Then addr 1 with 0x00000F0F, be 0x3.
- **Backpressure:** `vsew=2`, `vl=4`, `wr_ready` low 3 cycles on the first write.
  - Write outputs hold stable and `in_ready = 0` throughout.
  - All 4 words are written in order with no loss or duplication.
- **Zero length:** `vl=0`.
  - No `wr_en`; `done = 1` at cycle 1; `busy` never asserts.
- **Address wrap:** ADDR_W=5, `addr=31`, `vsew=2`, `vl=2`.
  - Writes to 31 then 0.
- **Reset / abort mid-operation:** `rst` (and `abort` when built with `PE_PACKER_ABORT_EN`) after 2 of 6 bytes.
  - All outputs go to 0 and no `done` is asserted.
  - A following `start` packs from slot 0.
